// File: rtl/router_ni_pkg.sv
// Shared definitions for the mesh network-interface slice.
//   - Packet field widths and header layout.
//   - ni_req_t: destination/mode request as seen by the legality check.
//   - mk_pkt(): assembles a right-aligned packet from request fields and payload.
package router_ni_pkg;

  localparam int JMP_W    = 8;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 4;
  localparam int HDR_W    = JMP_W + ROW_W + COL_W + 1;
  // Bit position of the mode flag inside the header; the payload sits below it.
  localparam int MODE_POS = 0;
  // Widest packet mk_pkt can build; callers cast the result down to their size.
  localparam int PKT_MAX  = 128;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
  } ni_req_t;

  // Header is {nxt_jmp=0, row, col, mode}; it is shifted above a pld_w-bit payload.
  function automatic logic [PKT_MAX-1:0] mk_pkt(input logic [ROW_W-1:0]   row,
                                                input logic [COL_W-1:0]   col,
                                                input logic               mode,
                                                input logic [PKT_MAX-1:0] pld,
                                                input int                 pld_w);
    logic [PKT_MAX-1:0] hdr;
    hdr = PKT_MAX'({{JMP_W{1'b0}}, row, col, mode});
    return (hdr << pld_w) | pld;
  endfunction

endpackage

// File: rtl/term_tx_ni_fifo.sv
// ni_fifo: first-word-fall-through synchronous FIFO.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push, din  : write request and data (ignored when full)
//   pop        : consume head (ignored when empty)
//   head       : current head entry, forced to 0 when empty
//   full, empty, count : occupancy status from the registered count
// DEPTH need not be a power of two; pointers wrap explicitly.
module ni_fifo #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 40,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  import router_ni_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only: never reset, head is gated by empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/term_tx_ni.sv
// term_tx_ni: source-side network interface feeding one mesh_gnrtr terminal port.
//   clk, reset           : clock, synchronous active-high reset
//   in_vld/in_rdy        : request handshake; in_row/in_col/in_mode/in_pld request fields
//   pndng_i_in           : a packet is waiting for the router
//   data_out_i_in        : head packet (0 when nothing is pending)
//   popin                : router consumes the head packet this cycle
//   drop_cnt             : saturating count of illegal (dropped) requests
//   tx_cnt, acc_cnt      : saturating pop/accept statistics
// Optional feature macro: TERM_TX_NI_STATS_EN. When undefined, tx_cnt and acc_cnt
// are tied to 0 and carry no logic.
module term_tx_ni
  import router_ni_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 10,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int id_row     = 0,
  parameter int id_column  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [3:0]         in_row,
  input  logic [3:0]         in_col,
  input  logic               in_mode,
  input  logic [pckg_sz-18:0] in_pld,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        tx_cnt,
  output logic [15:0]        acc_cnt
);

  localparam int PLD_W = pckg_sz - HDR_W;
  localparam int CW    = $clog2(fifo_depth + 1);
  // Destinations up to ROWS+1 / COLUMS+1 are reachable (edge terminals included).
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS + 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLUMS + 1);
  localparam logic [ROW_W-1:0] MY_ROW  = ROW_W'(id_row);
  localparam logic [COL_W-1:0] MY_COL  = COL_W'(id_column);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  ni_req_t              req;
  logic                 legal, xfer, push, drop, pop_ok;
  logic [pckg_sz-1:0]   pkt;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  assign req   = '{row: in_row, col: in_col, mode: in_mode};
  assign legal = !((req.row > ROW_MAX) || (req.col > COL_MAX) ||
                   ((req.row == MY_ROW) && (req.col == MY_COL)));

  // in_rdy looks only at registered occupancy, never at the same-cycle popin.
  assign in_rdy = !reset && !fifo_full;
  assign xfer   = in_vld && in_rdy;
  assign push   = xfer && legal;
  assign drop   = xfer && !legal;
  assign pop_ok = popin && !fifo_empty;

  assign pkt = pckg_sz'(mk_pkt(req.row, req.col, req.mode, PKT_MAX'(in_pld), PLD_W));

  ni_fifo #(.DEPTH(fifo_depth), .WIDTH(pckg_sz), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (pkt),
    .pop   (pop_ok),
    .head  (data_out_i_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pndng_i_in = (fifo_count != '0);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

`ifdef TERM_TX_NI_STATS_EN
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    tx_cnt_d  = tx_cnt_q;
    acc_cnt_d = acc_cnt_q;
    if (pop_ok) tx_cnt_d  = sat_inc(tx_cnt_q);
    if (push)   acc_cnt_d = sat_inc(acc_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_q  <= '0;
      acc_cnt_q <= '0;
    end else begin
      tx_cnt_q  <= tx_cnt_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign tx_cnt  = tx_cnt_q;
  assign acc_cnt = acc_cnt_q;
`else
  assign tx_cnt  = '0;
  assign acc_cnt = '0;
`endif

endmodule

// File: doc/term_tx_ni.md
Name: term_tx_ni

Overview:
- Source-side network interface for one mesh terminal; sits directly upstream of a mesh_gnrtr terminal port.
- Accepts destination/mode/payload requests from a traffic source with a valid/ready handshake and assembles mesh packets.
- Buffers packets in a first-word-fall-through FIFO and presents them on the router's pndng_i_in/data_out_i_in inputs; the router consumes them with popin.
- Drops illegal requests (out-of-range destination, self-addressed) and counts the drops.

Parameters:
- pckg_sz, 40, packet width in bits. Payload width PLD_W = pckg_sz-17.
- fifo_depth, 10, packet FIFO depth in entries, ≥2.
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- id_row, 0, this terminal's row id.
- id_column, 0, this terminal's column id.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_vld  in  1  request valid.
- in_rdy  out  1  request ready.
- in_row  in  4  destination row.
- in_col  in  4  destination column.
- in_mode  in  1  routing mode (0 = column first, 1 = row first).
- in_pld  in  PLD_W  payload.
- pndng_i_in  out  1  packet pending toward router.
- data_out_i_in  out  pckg_sz  head packet toward router.
- popin  in  1  router consumes the head packet.
- drop_cnt  out  16  illegal-request counter.
- tx_cnt  out  16  packets popped by router (statistics, see Optional Feature).
- acc_cnt  out  16  requests accepted into the FIFO (statistics, see Optional Feature).

Behaviour:
- Packet format, MSB first:
  - [pckg_sz-1 -: 8] nxt_jmp = 8'h00
  - [pckg_sz-9 -: 4] in_row
  - [pckg_sz-13 -: 4] in_col
  - [pckg_sz-17] in_mode
  - [PLD_W-1:0] in_pld
- Handshake:
  - in_rdy = !full, from the registered count only; it does not depend on the same-cycle popin.
  - A transfer occurs on a rising clk edge with in_vld && in_rdy.
  - in_vld may be held high across cycles.
- Legality check on transfer:
  - A request is illegal if in_row > ROWS+1, in_col > COLUMS+1, or (in_row==id_row && in_col==id_column).
  - Illegal requests are consumed (handshake completes), not written, and drop_cnt increments.
  - drop_cnt saturates at 16'hFFFF.
- Latency: a legal transfer at edge N makes the packet visible on data_out_i_in, with pndng_i_in=1, after edge N if the FIFO was empty. Otherwise it appears in order behind earlier packets.
- Router side:
  - pndng_i_in = (count != 0), registered.
  - data_out_i_in is always the head entry, fall-through.
  - popin with count==0 is ignored, with no pointer or count change.
  - popin is honoured in the same cycle it is asserted; the router never holds it for a second pop of the same packet.
- Simultaneous legal push and pop with 0 < count < depth: both pointers advance and count is unchanged.
- When full: no push, even if popin is high the same cycle; in_rdy rises the cycle after the pop.
- Pointers wrap from fifo_depth-1 to 0; fifo_depth need not be a power of two.
- Reset values (a reset in mid-operation flushes all content; in-flight requests are lost):
  - count = 0, pointers = 0, pndng_i_in = 0.
  - data_out_i_in = 0 (FIFO storage is not cleared; data_out_i_in is gated to 0 when empty).
  - in_rdy = 1 from the first edge after reset deasserts; it is 0 while reset is high.
  - drop_cnt = 0, tx_cnt = 0, acc_cnt = 0.

Optional Feature:
- Macro: TERM_TX_NI_STATS_EN.
- Defined:
  - tx_cnt increments on each honoured popin.
  - acc_cnt increments on each legal push.
  - Both are 16-bit, saturating, and cleared by reset.
- Undefined: tx_cnt and acc_cnt are tied to 0 and no counter logic is synthesised. drop_cnt is always present.

Decomposition:
- Package router_ni_pkg:
  - field width/offset localparams (JMP_W=8, ROW_W=4, COL_W=4, MODE_POS);
  - function mk_pkt(row, col, mode, pld);
  - packed struct ni_req_t.
- One sub-module, ni_fifo: parameterised FWFT synchronous FIFO (fifo_depth, width) exposing push, pop, head, full, empty and count.
- Legality check and counters stay in term_tx_ni.

Test Plan:
- Parameter set for all scenarios: pckg_sz=40, ROWS=COLUMS=4, id_row=0, id_column=1.
1. Reset, then push row=2, col=3, mode=1, pld=23'h012345 → the next cycle shows pndng_i_in=1 and data_out_i_in=40'h0023812345; popin for one cycle → pndng_i_in=0.
2. Push 10 legal packets with popin=0 → in_rdy=0 after the 10th; an 11th in_vld stalls; a single popin → in_rdy=1 the next cycle and the 11th is accepted; order is preserved.
3. Requests row=6 col=0, then row=0 col=1 (self), then row=1 col=6 → no FIFO write, pndng_i_in stays 0, drop_cnt=3.
4. Continuous in_vld with popin asserted every cycle once pending → count stays at 1, and 100 packets pass in order with no loss.
5. Assert reset while 5 packets are queued → the next cycle shows pndng_i_in=0, data_out_i_in=0 and drop_cnt=0; a new push then works normally.
6. With TERM_TX_NI_STATS_EN defined, run scenario 2 fully drained → acc_cnt=11, tx_cnt=11. Undefined → both read 0.
